binary_gray_converter: RTL and testbench
========================================

// Module: binary_gray_converter
// PURPOSE
//  2-bit binary-to-Gray / half-add cell. Inputs a (MSB) and b (LSB) form a 2-bit binary word.
//  S carries the Gray LSB (a XOR b, identical to the half-adder sum).
//  Cout carries the carry term (a AND b).
//  Leaf cell for small code-conversion and adder datapaths. Inputs may be asynchronous to clk,
//  so they are synchronised before use.
// PARAMETERS
//  SYNC_STAGES  2  flops per input synchroniser chain; legal 0..4 (0 = inputs used directly)
//  OUT_REG      1  1 = S/Cout driven from flops; 0 = S/Cout combinational from synchroniser outputs
// PORTS
//  clk    in   1  single clock; all flops rising-edge
//  rst_n  in   1  reset, asynchronous, active-low
//  a      in   1  binary MSB
//  b      in   1  binary LSB
//  S      out  1  a XOR b (Gray bit 0 / sum)
//  Cout   out  1  a AND b (carry)
// BEHAVIOUR
//  Reset
//   - rst_n=0 immediately clears every synchroniser flop and both output flops, independent of clk.
//   - S=0 and Cout=0 while reset is held.
//   - Release is sampled on the next rising clk edge.
//  Synchroniser
//   - a and b each pass through an independent SYNC_STAGES-deep flop chain.
//   - Both chains have equal depth, so a and b stay aligned relative to each other.
//  Logic
//   - s_nxt = a_s ^ b_s; c_nxt = a_s & b_s; a_s/b_s are the last-stage synchroniser outputs.
//  Latency
//   - SYNC_STAGES + OUT_REG rising edges from an input change to the output change.
//   - Defaults give 3 cycles.
//   - With SYNC_STAGES=0 and OUT_REG=0 the block is purely combinational; rst_n has no effect
//     except when flops exist.
//  Truth table (after latency)
//   - a,b = 00 -> S,Cout = 0,0
//   - a,b = 01 -> S,Cout = 1,0
//   - a,b = 10 -> S,Cout = 1,0
//   - a,b = 11 -> S,Cout = 0,1
//  Simultaneous changes
//   - a and b changing in the same cycle produce a single output update; no intermediate code
//     appears, because both chains share the same depth.
//   - S and Cout are never both 1.
//  Reset mid-operation
//   - Asserting reset discards any in-flight values; outputs drop to 0 at once.
//   - After release, outputs reflect live inputs once the latency has elapsed.
//   - Outputs stay 0 during the refill.
//  Input glitch
//   - A pulse shorter than one clk period may be lost; this is acceptable.
//   - Any pulse held for at least 1 clk period must propagate.
//  Misc
//   - No X propagation from reset state: all flops have a defined reset value.
//   - Parameter outside the legal range: compile-time error via generate check.
// TESTING
//  1. rst_n=0 with a=1,b=1 -> S=0,Cout=0 immediately, without a clk edge.
//  2. Release reset, a=0,b=0 held -> S=0,Cout=0 for every cycle.
//  3. Step a,b through 00,01,10,11, each held 4 clk -> S,Cout = 00,10,10,01, appearing
//     3 edges after each step (defaults).
//  4. Toggle a every 2 clk and b every 1 clk (square waves) -> every cycle S==a^b and
//     Cout==a&b, delayed by 3 cycles; S&Cout never 1.
//  5. a=1,b=1 settled (Cout=1), assert rst_n=0 mid-cycle -> Cout=0 async; release ->
//     Cout returns to 1 after 3 edges.
//  6. SYNC_STAGES=0, OUT_REG=0 -> outputs follow inputs with zero cycles;
//     SYNC_STAGES=1, OUT_REG=1 -> 2-cycle latency.

Source files
------------

// File: rtl/binary_gray_converter_if.sv
// Bus bundle for binary_gray_converter.
//   a, b    : 2-bit binary word (a = MSB, b = LSB), driven by the master
//   S, Cout : Gray bit 0 / half-add sum and carry, driven by the converter
// The converter connects to the slave modport. The stimulus side connects to the master modport.
interface binary_gray_converter_if;
  logic a;
  logic b;
  logic S;
  logic Cout;

  modport master (output a, b, input  S, Cout);
  modport slave  (input  a, b, output S, Cout);
endinterface

// File: rtl/binary_gray_converter.sv
// binary_gray_converter: 2-bit binary-to-Gray / half-add leaf cell.
//   clk   : single rising-edge clock
//   rst_n : asynchronous active-low reset, clears every flop
//   bus   : slave side of binary_gray_converter_if
//           a, b in  : binary word, possibly asynchronous to clk
//           S    out : a ^ b  (Gray bit 0 / sum)
//           Cout out : a & b  (carry)
// Latency from an input change to the output change is SYNC_STAGES + OUT_REG rising edges.

// Synchronises one input bit through a STAGES-deep flop chain.
// STAGES = 0 turns the chain into a wire.
module binary_gray_converter_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  if (STAGES == 0) begin : g_bypass
    assign q = d;
    // In the wire configuration the clock and reset are not used.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end else begin : g_chain
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ff <= '0;
      end else begin
        ff[0] <= d;
        for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
      end
    end
    assign q = ff[STAGES-1];
  end
endmodule

module binary_gray_converter #(
  parameter int SYNC_STAGES = 2,
  parameter int OUT_REG     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  binary_gray_converter_if.slave bus
);
  if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("binary_gray_converter: SYNC_STAGES must be 0..4");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_oreg
    $error("binary_gray_converter: OUT_REG must be 0 or 1");
  end

  // Lane 1 carries a and lane 0 carries b. Both lanes have the same depth, so a change on
  // both inputs in one cycle reaches the logic together. No mixed code can appear between
  // the old and the new value.
  logic [1:0] din;
  logic [1:0] dsync;
  assign din = {bus.a, bus.b};

  binary_gray_converter_sync #(.STAGES(SYNC_STAGES)) u_sync [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (dsync)
  );

  logic a_s, b_s, s_nxt, c_nxt;
  assign a_s   = dsync[1];
  assign b_s   = dsync[0];
  assign s_nxt = a_s ^ b_s;
  assign c_nxt = a_s & b_s;

  if (OUT_REG == 1) begin : g_oreg
    logic s_q, c_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= 1'b0;
        c_q <= 1'b0;
      end else begin
        s_q <= s_nxt;
        c_q <= c_nxt;
      end
    end
    assign bus.S    = s_q;
    assign bus.Cout = c_q;
  end else begin : g_comb
    assign bus.S    = s_nxt;
    assign bus.Cout = c_nxt;
  end
endmodule

// File: tb/tb_binary_gray_converter.sv
module tb_binary_gray_converter;
  logic clk;
  logic rst_n;

  binary_gray_converter_if if3 ();  // defaults: 2 sync + out reg -> 3 cycles
  binary_gray_converter_if if0 ();  // 0 sync, no out reg -> combinational
  binary_gray_converter_if if2 ();  // 1 sync + out reg -> 2 cycles

  binary_gray_converter u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  binary_gray_converter #(.SYNC_STAGES(0), .OUT_REG(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  binary_gray_converter #(.SYNC_STAGES(1), .OUT_REG(1))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic a;
    logic b;
    logic s;
    logic c;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [1:0] q3[$];   // expected {S,Cout} for u_dut3
  logic [1:0] q2[$];   // expected {S,Cout} for u_dut2

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got S,Cout=%b required %b", name, $time, act, exp);
    end
  endtask

  // A registered DUT emits zeros while it refills after reset.
  // The number of zeros is its latency minus the cycle that pushes the first live value.
  task automatic restart_sb();
    q3.delete(); q2.delete();
    q3.push_back(2'b00); q3.push_back(2'b00);
    q2.push_back(2'b00);
  endtask

  task automatic drive(input logic a, input logic b);
    if3.a = a; if3.b = b;
    if0.a = a; if0.b = b;
    if2.a = a; if2.b = b;
  endtask

  // Called at a negedge. It drives the inputs and checks the combinational DUT at once.
  // It queues the expected values and checks the registered DUTs after the next posedge.
  task automatic step(input logic a, input logic b, input logic es, input logic ec, input string name);
    logic [1:0] e;
    drive(a, b);
    #1;
    chk({name, "/comb"}, {if0.S, if0.Cout}, {es, ec});
    q3.push_back({es, ec});
    q2.push_back({es, ec});
    @(posedge clk); #1;
    if (q3.size() == 0 || q2.size() == 0) begin
      chk({name, "/sb_empty"}, 2'b11, 2'b00);
    end else begin
      e = q3.pop_front();
      chk({name, "/lat3"}, {if3.S, if3.Cout}, e);
      e = q2.pop_front();
      chk({name, "/lat2"}, {if2.S, if2.Cout}, e);
    end
    if (if3.S && if3.Cout) chk({name, "/excl"}, {if3.S, if3.Cout}, 2'b10);
    @(negedge clk);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{a:1'b0, b:1'b0, s:1'b0, c:1'b0};
    tbl[1] = '{a:1'b0, b:1'b1, s:1'b1, c:1'b0};
    tbl[2] = '{a:1'b1, b:1'b0, s:1'b1, c:1'b0};
    tbl[3] = '{a:1'b1, b:1'b1, s:1'b0, c:1'b1};

    // Asynchronous reset with a=b=1, checked before any clock edge.
    rst_n = 1'b1;
    drive(1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_lat3", {if3.S, if3.Cout}, 2'b00);
    chk("rst_async_lat2", {if2.S, if2.Cout}, 2'b00);
    chk("rst_comb_follow", {if0.S, if0.Cout}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_held_lat3", {if3.S, if3.Cout}, 2'b00);
      chk("rst_held_lat2", {if2.S, if2.Cout}, 2'b00);
    end

    // Release with a=b=0 held.
    @(negedge clk);
    drive(1'b0, 1'b0);
    rst_n = 1'b1;
    restart_sb();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "zero_hold");

    // Walk the truth table with each word held for 4 cycles.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        step(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, "table");

    // Square waves: a toggles every 2 cycles and b every cycle. Both can change together.
    for (int k = 0; k < 20; k++) begin
      logic sa, sb;
      sa = 1'((k / 2) % 2);
      sb = 1'(k % 2);
      step(sa, sb, sa ^ sb, sa & sb, "square");
    end

    // Settle at 11, then assert reset in mid-cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, "settle11");
    chk("pre_rst_lat3", {if3.S, if3.Cout}, 2'b01);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_lat3", {if3.S, if3.Cout}, 2'b00);
    chk("midrst_lat2", {if2.S, if2.Cout}, 2'b00);
    chk("midrst_comb", {if0.S, if0.Cout}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    restart_sb();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, "refill11");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish by 100000");
    $fatal(1, "timeout");
  end
endmodule
